// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/control bundle between the pipeline datapath and the stall sequencer.
// HAZARD_PERF_CNT_EN adds the performance counter outputs.
interface hazard_stall_ctrl_if;
  logic       id_ex_memread;
  logic [4:0] id_ex_rd;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic       if_id_use_rs1;
  logic       if_id_use_rs2;
  logic       ex_branch_taken;
  logic       ex_md_valid;
  logic       ext_stall;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_write;
  logic       id_ex_flush;
  logic       ex_mem_write;
  logic       ex_mem_flush;
  logic       mem_wb_write;
  logic       md_busy;
  logic       md_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  // Datapath side: supplies hazard info, consumes the stage controls.
  modport master (
    output id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2,
    output ex_branch_taken, ex_md_valid, ext_stall,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
    input  ex_mem_write, ex_mem_flush, mem_wb_write, md_busy, md_done
`ifdef HAZARD_PERF_CNT_EN
    , input perf_stall_cycles, perf_flush_count
`endif
  );

  // Sequencer side.
  modport slave (
    input  id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2,
    input  ex_branch_taken, ex_md_valid, ext_stall,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
    output ex_mem_write, ex_mem_flush, mem_wb_write, md_busy, md_done
`ifdef HAZARD_PERF_CNT_EN
    , output perf_stall_cycles, perf_flush_count
`endif
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencer: load-use, redirect squash, multi-cycle mul/div, memory freeze.
// HAZARD_PERF_CNT_EN adds stall-cycle and flush counters.
module hazard_stall_ctrl #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 4
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_ctrl_if.slave hz
);

  typedef enum logic {StRun, StMdBusy} state_e;

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(MD_LAT - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;
  logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_w, busy, done;

  assign lu = hz.id_ex_memread && (hz.id_ex_rd != 5'd0) &&
              ((hz.if_id_use_rs1 && (hz.if_id_rs1 == hz.id_ex_rd)) ||
               (hz.if_id_use_rs2 && (hz.if_id_rs2 == hz.id_ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    ifid_f  = 1'b0;
    idex_w  = 1'b1;
    idex_f  = 1'b0;
    exmem_w = 1'b1;
    exmem_f = 1'b0;
    memwb_w = 1'b1;
    busy    = (state_q == StMdBusy);
    done    = 1'b0;

    if (hz.ext_stall) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      exmem_w = 1'b0;
      memwb_w = 1'b0;
    end else if ((state_q == StRun && hz.ex_md_valid) || (state_q == StMdBusy && cnt_q != '0)) begin
      // Hold the op in EX, let older instructions drain, bubble into EX/MEM.
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      exmem_f = 1'b1;
      if (state_q == StRun) begin
        state_d = StMdBusy;
        cnt_d   = CntInit;
      end else begin
        cnt_d   = cnt_q - 1'b1;
      end
    end else begin
      if (state_q == StMdBusy) begin
        done    = 1'b1;
        state_d = StRun;
      end
      if (hz.ex_branch_taken) begin
        ifid_f = 1'b1;
        idex_f = 1'b1;
      end else if (lu) begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        idex_f = 1'b1;
      end
    end

    if (!rst_n) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      ifid_f  = 1'b0;
      idex_w  = 1'b0;
      idex_f  = 1'b0;
      exmem_w = 1'b0;
      exmem_f = 1'b0;
      memwb_w = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
    end
  end

  assign hz.pc_write     = pc_w;
  assign hz.if_id_write  = ifid_w;
  assign hz.if_id_flush  = ifid_f;
  assign hz.id_ex_write  = idex_w;
  assign hz.id_ex_flush  = idex_f;
  assign hz.ex_mem_write = exmem_w;
  assign hz.ex_mem_flush = exmem_f;
  assign hz.mem_wb_write = memwb_w;
  assign hz.md_busy      = busy;
  assign hz.md_done      = done;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (!pc_w)  perf_stall_q <= perf_stall_q + 32'd1;
      if (ifid_f) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign hz.perf_stall_cycles = perf_stall_q;
  assign hz.perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table, directed mul/div sequences,
// random stimulus against an occupancy-count reference model.
module tb_hazard_stall_ctrl;
  localparam int unsigned Lat = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   md_left = 0;  // remaining EX cycles of the op in flight, after the current one

  hazard_stall_ctrl_if hz ();
  hazard_stall_ctrl_if hz2 ();

  hazard_stall_ctrl #(.MD_LAT(Lat), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
  hazard_stall_ctrl #(.MD_LAT(2), .CNT_W(4)) dut2 (.clk(clk), .rst_n(rst_n), .hz(hz2));

  assign hz2.id_ex_memread   = hz.id_ex_memread;
  assign hz2.id_ex_rd        = hz.id_ex_rd;
  assign hz2.if_id_rs1       = hz.if_id_rs1;
  assign hz2.if_id_rs2       = hz.if_id_rs2;
  assign hz2.if_id_use_rs1   = hz.if_id_use_rs1;
  assign hz2.if_id_use_rs2   = hz.if_id_use_rs2;
  assign hz2.ex_branch_taken = hz.ex_branch_taken;
  assign hz2.ex_md_valid     = hz.ex_md_valid;
  assign hz2.ext_stall       = hz.ext_stall;

  always #5 clk = ~clk;

  // {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_w, md_busy, md_done}
  localparam logic [9:0] Dflt  = 10'b1101010100;
  localparam logic [9:0] LuSt  = 10'b0001110100;
  localparam logic [9:0] Squash = 10'b1111110100;
  localparam logic [9:0] MdSt0 = 10'b0000011100;
  localparam logic [9:0] MdStB = 10'b0000011110;
  localparam logic [9:0] MdDn  = 10'b1101010111;

  typedef struct {
    logic       mr;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, br, md, es;
    logic [9:0] exp;
  } vec_t;

  vec_t tab[12];

  function automatic logic [9:0] outs1();
    return {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_write, hz.id_ex_flush,
            hz.ex_mem_write, hz.ex_mem_flush, hz.mem_wb_write, hz.md_busy, hz.md_done};
  endfunction

  function automatic logic [9:0] outs2();
    return {hz2.pc_write, hz2.if_id_write, hz2.if_id_flush, hz2.id_ex_write, hz2.id_ex_flush,
            hz2.ex_mem_write, hz2.ex_mem_flush, hz2.mem_wb_write, hz2.md_busy, hz2.md_done};
  endfunction

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2, input logic br,
                       input logic md, input logic es);
    hz.id_ex_memread   = mr;
    hz.id_ex_rd        = rd;
    hz.if_id_rs1       = rs1;
    hz.if_id_rs2       = rs2;
    hz.if_id_use_rs1   = u1;
    hz.if_id_use_rs2   = u2;
    hz.ex_branch_taken = br;
    hz.ex_md_valid     = md;
    hz.ext_stall       = es;
  endtask

  // Reference: outputs from the spec's priority list and the count of remaining EX cycles.
  task automatic model(output logic [9:0] exp, output int nxt);
    logic lu;
    lu = hz.id_ex_memread && hz.id_ex_rd != 0 &&
         ((hz.if_id_use_rs1 && hz.if_id_rs1 == hz.id_ex_rd) ||
          (hz.if_id_use_rs2 && hz.if_id_rs2 == hz.id_ex_rd));
    nxt = md_left;
    if (!rst_n) begin
      exp = '0;
      nxt = 0;
    end else if (hz.ext_stall) begin
      exp = (md_left > 0) ? 10'b0000000010 : 10'b0;
    end else if (md_left > 1) begin
      exp = MdStB;
      nxt = md_left - 1;
    end else if (md_left == 0 && hz.ex_md_valid) begin
      exp = MdSt0;
      nxt = Lat - 1;
    end else begin
      exp = (md_left == 1) ? MdDn : Dflt;
      nxt = 0;
      if (hz.ex_branch_taken) begin
        exp[7] = 1'b1;
        exp[5] = 1'b1;
      end else if (lu) begin
        exp[9] = 1'b0;
        exp[8] = 1'b0;
        exp[5] = 1'b1;
      end
    end
  endtask

  // Inputs already driven at the negedge; check, cross the posedge, return at next negedge.
  task automatic step(input string name, input logic use_exp, input logic [9:0] exp_in,
                      input logic chk2, input logic [9:0] exp2);
    logic [9:0] mexp;
    int nxt;
    #1;
    model(mexp, nxt);
    check(name, outs1(), use_exp ? exp_in : mexp);
    if (chk2) check({name, "_lat2"}, outs2(), exp2);
    @(posedge clk);
    md_left = nxt;
    @(negedge clk);
  endtask

  initial begin
    tab[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Dflt};
    tab[1]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, LuSt};
    tab[2]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, Dflt};
    tab[3]  = '{1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LuSt};
    tab[4]  = '{1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Dflt};
    tab[5]  = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, Dflt};
    tab[6]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, Squash};
    tab[7]  = '{1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, Squash};
    tab[8]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'b0};
    tab[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'b0};
    tab[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'b0};
    tab[11] = '{1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Dflt};

    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    check("reset_outputs", outs1(), 10'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tab[i].mr, tab[i].rd, tab[i].rs1, tab[i].rs2, tab[i].u1, tab[i].u2, tab[i].br,
            tab[i].md, tab[i].es);
      step($sformatf("vec%0d", i), 1'b1, tab[i].exp, 1'b0, 10'b0);
    end

    // Load-use then the load leaves ID/EX.
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_stall", 1'b1, LuSt, 1'b0, 10'b0);
    drive(1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_after", 1'b1, Dflt, 1'b0, 10'b0);

    // mul/div held valid for 4 cycles; the MD_LAT=2 instance finishes after one stall.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("md_c0", 1'b1, MdSt0, 1'b1, MdSt0);
    step("md_c1", 1'b1, MdStB, 1'b1, MdDn);
    step("md_c2", 1'b1, MdStB, 1'b0, 10'b0);
    step("md_c3", 1'b1, MdDn, 1'b0, 10'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("md_c4", 1'b1, Dflt, 1'b1, Dflt);

    // ext_stall while the counter sits at 1.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("es_md0", 1'b1, MdSt0, 1'b0, 10'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("es_md1", 1'b1, MdStB, 1'b0, 10'b0);
    hz.ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("es_hold%0d", i), 1'b1, 10'b0000000010, 1'b0,
                                     10'b0);
    hz.ext_stall = 1'b0;
    step("es_rel0", 1'b1, MdStB, 1'b0, 10'b0);
    step("es_rel1", 1'b1, MdDn, 1'b0, 10'b0);
    step("es_run", 1'b1, Dflt, 1'b0, 10'b0);

    // Reset in the middle of an op.
    hz.ex_md_valid = 1'b1;
    step("rst_md0", 1'b1, MdSt0, 1'b0, 10'b0);
    hz.ex_md_valid = 1'b0;
    step("rst_md1", 1'b1, MdStB, 1'b0, 10'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", outs1(), 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
    md_left = 0;
    step("rst_release", 1'b1, Dflt, 1'b0, 10'b0);
    step("rst_release2", 1'b1, Dflt, 1'b1, Dflt);

`ifdef HAZARD_PERF_CNT_EN
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("perf_lu", 1'b1, LuSt, 1'b0, 10'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("perf_br", 1'b1, Squash, 1'b0, 10'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("perf_md0", 1'b1, MdSt0, 1'b0, 10'b0);
    hz.ex_md_valid = 1'b0;
    step("perf_md1", 1'b1, MdStB, 1'b0, 10'b0);
    step("perf_md2", 1'b1, MdStB, 1'b0, 10'b0);
    step("perf_md3", 1'b1, MdDn, 1'b0, 10'b0);
    total++;
    if (hz.perf_stall_cycles !== 32'd4 || hz.perf_flush_count !== 32'd1) begin
      bad++;
      $display("FAIL perf_counts: got stall=%0d flush=%0d want stall=4 flush=1",
               hz.perf_stall_cycles, hz.perf_flush_count);
    end
`endif

    // Random traffic against the reference model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0));
      rst_n = ($urandom_range(0, 59) != 0);
      step($sformatf("rand%0d", n), 1'b0, 10'b0, 1'b0, 10'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32 core. It generates per-stage write-enable and flush controls that freeze, bubble or squash pipeline registers.
- Load-use: one-cycle stall that the EX forwarding network cannot cover.
- Taken branch/jump in EX: squash of the two younger instructions.
- Multi-cycle mul/div in EX: holds the op in EX for a fixed latency.
- External memory stall: freezes the whole pipe.

Parameters:
MD_LAT, 4, total EX-occupancy cycles of a mul/div op (legal 2..16)
CNT_W, 4, width of latency counter (must hold MD_LAT-2)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_ex_memread  in  1  instruction in ID/EX is a load
id_ex_rd  in  5  destination of ID/EX instruction
if_id_rs1  in  5  rs1 of decoding instruction
if_id_rs2  in  5  rs2 of decoding instruction
if_id_use_rs1  in  1  decoding instruction reads rs1
if_id_use_rs2  in  1  decoding instruction reads rs2
ex_branch_taken  in  1  EX resolved redirect (branch taken / jal / jalr)
ex_md_valid  in  1  EX holds a mul/div op
ext_stall  in  1  data memory not ready; freeze everything
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID to NOP
id_ex_write  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX to bubble (all control zero)
ex_mem_write  out  1  EX/MEM load enable
ex_mem_flush  out  1  EX/MEM to bubble
mem_wb_write  out  1  MEM/WB load enable
md_busy  out  1  FSM in MD_BUSY
md_done  out  1  one-cycle pulse: mul/div result leaves EX this cycle

Behaviour:
- Registered state: 1-bit FSM {RUN, MD_BUSY} and a CNT_W-bit counter. All outputs are combinational from state, counter and inputs.
- Reset (rst_n=0, async): state=RUN, cnt=0.
  - While in reset: all *_write=0, all *_flush=0, md_busy=0, md_done=0.
- Default, RUN with no event: all *_write=1, all *_flush=0.
- Load-use hazard (lu) asserts when all of the following hold:
  - id_ex_memread=1
  - id_ex_rd!=0
  - (if_id_use_rs1 and if_id_rs1==id_ex_rd) or (if_id_use_rs2 and if_id_rs2==id_ex_rd)
- Priority, highest first:
  1. ext_stall=1: every *_write=0, flushes=0, md_done=0. State and cnt hold. Overrides everything, including the MD_BUSY exit.
  2. RUN and ex_md_valid=1:
     - Outputs: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1, mem_wb_write=1.
     - Next state: state<=MD_BUSY, cnt<=MD_LAT-2.
     - ex_branch_taken is ignored (mutually exclusive by decode).
  3. MD_BUSY and cnt!=0: same outputs as (2); cnt<=cnt-1.
  4. MD_BUSY and cnt==0:
     - md_done=1; all writes=1 (op advances); state<=RUN.
     - ex_md_valid is ignored in MD_BUSY. Branch and lu evaluation apply as in RUN.
  5. ex_branch_taken=1: if_id_flush=1, id_ex_flush=1, all writes=1. Wins over lu because the stalled instruction is squashed anyway.
  6. lu=1: pc_write=0, if_id_write=0, id_ex_flush=1, other writes=1. Exactly one bubble; the next cycle re-evaluates with the new ID/EX.
- Mul/div timing: the op occupies EX for exactly MD_LAT non-ext_stall cycles, with MD_LAT-1 stall cycles. md_busy=1 for MD_LAT-1 cycles.
- Reset mid-MD_BUSY aborts the sequence immediately; there is no md_done pulse.
- rd==x0 never causes a stall.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_count[31:0], both reset to 0.
  - perf_stall_cycles increments in every non-reset cycle with pc_write=0 (includes ext_stall).
  - perf_flush_count increments on each cycle with if_id_flush=1.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rd=5, if_id_rs2=5, use_rs2=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; next cycle with memread=0 all writes=1. Repeat with rd=0 -> no stall.
- Branch+lu same cycle: ex_branch_taken=1 with lu condition true -> if_id_flush=1, id_ex_flush=1, pc_write=1.
- MD_LAT=4: ex_md_valid=1 held 4 cycles:
  - Cycles 0-2: pc_write=0, ex_mem_flush=1, md_busy=0/1/1.
  - Cycle 3: md_done=1, all writes=1.
  - Cycle 4: RUN.
  - Repeat with MD_LAT=2 -> one stall cycle.
- ext_stall during MD_BUSY at cnt=1 for 3 cycles -> all writes=0, cnt stays 1, no md_done; done arrives 2 cycles after release.
- rst_n low mid-MD_BUSY -> outputs immediately writes=0, md_busy=0; after release state=RUN, default writes=1, no md_done.
- HAZARD_PERF_CNT_EN: 1 load-use + 1 branch + one MD_LAT=4 op -> perf_stall_cycles=4, perf_flush_count=1. Force counter to 0xFFFFFFFF, then one stall -> 0.
